// File: rtl/axi_sram_slave_p.sv
// AXI4 slave serving one burst at a time from a single-port SRAM with 1-cycle read latency.
// WRAP bursts are honoured only when AXI_SRAM_WRAP_EN is defined; otherwise they complete with SLVERR.
module axi_sram_slave_p #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int ID_W    = 8,
  parameter int SRAM_AW = 14,
  localparam int STRB_W = DATA_W / 8,
  localparam int OFF    = $clog2(STRB_W)
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic [ID_W-1:0]    ARID,
  input  logic [ADDR_W-1:0]  ARADDR,
  input  logic [7:0]         ARLEN,
  input  logic [2:0]         ARSIZE,
  input  logic [1:0]         ARBURST,
  input  logic               ARVALID,
  output logic               ARREADY,
  output logic [ID_W-1:0]    RID,
  output logic [DATA_W-1:0]  RDATA,
  output logic [1:0]         RRESP,
  output logic               RLAST,
  output logic               RVALID,
  input  logic               RREADY,
  input  logic [ID_W-1:0]    AWID,
  input  logic [ADDR_W-1:0]  AWADDR,
  input  logic [7:0]         AWLEN,
  input  logic [2:0]         AWSIZE,
  input  logic [1:0]         AWBURST,
  input  logic               AWVALID,
  output logic               AWREADY,
  input  logic [DATA_W-1:0]  WDATA,
  input  logic [STRB_W-1:0]  WSTRB,
  input  logic               WLAST,
  input  logic               WVALID,
  output logic               WREADY,
  output logic [ID_W-1:0]    BID,
  output logic [1:0]         BRESP,
  output logic               BVALID,
  input  logic               BREADY,
  output logic [STRB_W-1:0]  SRAM_WEB,
  output logic [SRAM_AW-1:0] SRAM_A,
  output logic [DATA_W-1:0]  SRAM_DI,
  input  logic [DATA_W-1:0]  SRAM_DO
);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state_q, state_d;
  logic              rr_q;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q, cnt_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              bad_q;
  logic [1:0]        bresp_q;
  logic              rd_done_q, rvalid_q, rfresh_q, rlast_q, rzero_q;
  logic [1:0]        rresp_q;
  logic [DATA_W-1:0] rhold_q;

  logic              arready, awready, wready, bvalid;
  logic              ar_hs, aw_hs, w_hs, r_hs, rd_issue;
  logic              beat_dec, beat_last;
  logic [1:0]        beat_resp, wbeat_resp;
  logic [ADDR_W-1:0] step, wrap_mask, next_addr;

  // Illegal size or unsupported WRAP: every beat errors and nothing touches the SRAM.
  function automatic logic bad_burst(input logic [2:0] size, input logic [7:0] len,
                                     input logic [1:0] burst);
    logic bad;
    bad = int'(size) > OFF;
`ifdef AXI_SRAM_WRAP_EN
    if (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) bad = 1'b1;
`else
    if (burst == 2'b10 && len != 8'hFF) bad = 1'b1;
    if (burst == 2'b10) bad = 1'b1;
`endif
    return bad;
  endfunction

  always_comb begin
    state_d = state_q;
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        arready = ARVALID && (!AWVALID || !rr_q);
        awready = AWVALID && (!ARVALID || rr_q);
        if (ARVALID && arready)      state_d = READ;
        else if (AWVALID && awready) state_d = WRITE;
      end
      READ:  if (rvalid_q && RREADY && rlast_q) state_d = IDLE;
      WRITE: begin
        wready = 1'b1;
        if (WVALID && cnt_q == len_q) state_d = RESP;
      end
      RESP: begin
        bvalid = 1'b1;
        if (BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign ar_hs     = ARVALID && arready;
  assign aw_hs     = AWVALID && awready;
  assign w_hs      = WVALID && wready;
  assign r_hs      = rvalid_q && RREADY;
  // Fetch only when the output slot frees up next cycle, so stalls never drop SRAM data.
  assign rd_issue  = (state_q == READ) && !rd_done_q && (!rvalid_q || RREADY);
  assign beat_last = (cnt_q == len_q);
  assign beat_dec  = |addr_q[ADDR_W-1:SRAM_AW+OFF];
  assign beat_resp = beat_dec ? DECERR : (bad_q ? SLVERR : OKAY);

  always_comb begin
    wbeat_resp = beat_resp;
    if (wbeat_resp == OKAY && (WLAST != beat_last)) wbeat_resp = SLVERR;
  end

  always_comb begin
    step      = ADDR_W'(1) << size_q;
    wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default: next_addr = addr_q + step;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rr_q      <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      bad_q     <= 1'b0;
      bresp_q   <= OKAY;
      rd_done_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rfresh_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rzero_q   <= 1'b0;
      rresp_q   <= OKAY;
      rhold_q   <= '0;
    end else begin
      if (state_q == IDLE && ARVALID && AWVALID) rr_q <= ~rr_q;
      if (ar_hs) begin
        id_q      <= ARID;
        addr_q    <= ARADDR;
        len_q     <= ARLEN;
        size_q    <= ARSIZE;
        burst_q   <= ARBURST;
        bad_q     <= bad_burst(ARSIZE, ARLEN, ARBURST);
        cnt_q     <= '0;
        rd_done_q <= 1'b0;
      end else if (aw_hs) begin
        id_q    <= AWID;
        addr_q  <= AWADDR;
        len_q   <= AWLEN;
        size_q  <= AWSIZE;
        burst_q <= AWBURST;
        bad_q   <= bad_burst(AWSIZE, AWLEN, AWBURST);
        cnt_q   <= '0;
        bresp_q <= OKAY;
      end
      if (rd_issue || w_hs) begin
        addr_q <= next_addr;
        cnt_q  <= cnt_q + 8'd1;
      end
      if (rd_issue) begin
        rd_done_q <= beat_last;
        rlast_q   <= beat_last;
        rresp_q   <= beat_resp;
        rzero_q   <= (beat_resp != OKAY);
      end
      if (w_hs && wbeat_resp > bresp_q) bresp_q <= wbeat_resp;
      if (rd_issue)  rvalid_q <= 1'b1;
      else if (r_hs) rvalid_q <= 1'b0;
      rfresh_q <= rd_issue;
      if (rfresh_q) rhold_q <= SRAM_DO;
    end
  end

  assign ARREADY  = arready;
  assign AWREADY  = awready;
  assign WREADY   = wready;
  assign BVALID   = bvalid;
  assign BID      = id_q;
  assign BRESP    = bresp_q;
  assign RID      = id_q;
  assign RVALID   = rvalid_q;
  assign RLAST    = rvalid_q && rlast_q;
  assign RRESP    = rvalid_q ? rresp_q : OKAY;
  assign RDATA    = (rvalid_q && !rzero_q) ? (rfresh_q ? SRAM_DO : rhold_q) : '0;

  assign SRAM_A   = (rd_issue || w_hs) ? addr_q[SRAM_AW+OFF-1:OFF] : '0;
  assign SRAM_DI  = w_hs ? WDATA : '0;
  assign SRAM_WEB = (w_hs && beat_resp == OKAY) ? ~WSTRB : '1;

endmodule

// File: tb/tb_axi_sram_slave_p.sv
// Directed bench for axi_sram_slave_p with a behavioural 1-cycle SRAM; memory word i starts as 0xA000_0000|i.
module tb_axi_sram_slave_p;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [7:0]  ARID = '0, AWID = '0, RID, BID;
  logic [31:0] ARADDR = '0, AWADDR = '0, RDATA, WDATA = '0, SRAM_DI, SRAM_DO;
  logic [7:0]  ARLEN = '0, AWLEN = '0;
  logic [2:0]  ARSIZE = '0, AWSIZE = '0;
  logic [1:0]  ARBURST = '0, AWBURST = '0, RRESP, BRESP;
  logic        ARVALID = 1'b0, AWVALID = 1'b0, WVALID = 1'b0, WLAST = 1'b0;
  logic        RREADY = 1'b0, BREADY = 1'b0;
  logic        ARREADY, AWREADY, WREADY, RVALID, RLAST, BVALID;
  logic [3:0]  WSTRB = '0, SRAM_WEB;
  logic [13:0] SRAM_A;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_dat [0:15];
  logic [1:0]  rd_resp[0:15];
  logic        rd_last[0:15];
  logic [7:0]  rd_id;
  int          rd_n;
  logic [13:0] w_a  [0:15];
  logic [3:0]  w_web[0:15];
  logic [1:0]  b_resp;
  logic [7:0]  b_id;

  logic [31:0] mem [0:16383];
  bit          mem_init;

  axi_sram_slave_p dut (
    .CLK(CLK), .RSTn(RSTn),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .SRAM_WEB(SRAM_WEB), .SRAM_A(SRAM_A), .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      mem_init <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++)
        if (!SRAM_WEB[i]) mem[SRAM_A][i*8 +: 8] <= SRAM_DI[i*8 +: 8];
    end
    SRAM_DO <= mem[SRAM_A];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic ar_hs(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    #1;
    while (!ARREADY && n < 20) begin @(negedge CLK); #1; n++; end
    chk("ar_rdy", 64'(ARREADY), 1);
    @(negedge CLK);
    ARVALID = 1'b0;
  endtask

  task automatic aw_hs(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    #1;
    while (!AWREADY && n < 20) begin @(negedge CLK); #1; n++; end
    chk("aw_rdy", 64'(AWREADY), 1);
    @(negedge CLK);
    AWVALID = 1'b0;
  endtask

  // Called at the negedge right after the AR handshake: checks the 2-cycle RVALID latency.
  task automatic rd_lat;
    chk("rlat_c1", 64'(RVALID), 0);
    @(negedge CLK);
    chk("rlat_c2", 64'(RVALID), 1);
  endtask

  task automatic rd_collect(input int stall_beat, input int stall_n,
                            input logic [31:0] stall_exp, input int max_beats);
    int  cyc = 0;
    int  st = 0;
    bit  done = 0;
    rd_n = 0;
    while (!done && cyc < 100) begin
      if (RVALID && rd_n == stall_beat && st < stall_n) begin
        RREADY = 1'b0;
        #1;
        chk($sformatf("stall_dat%0d", st), 64'(RDATA), 64'(stall_exp));
        chk($sformatf("stall_last%0d", st), 64'(RLAST), 0);
        st++;
      end else if (RVALID) begin
        RREADY = 1'b1;
        rd_dat[rd_n] = RDATA; rd_resp[rd_n] = RRESP; rd_last[rd_n] = RLAST; rd_id = RID;
        rd_n++;
        if (RLAST || rd_n == max_beats) done = 1;
      end else begin
        RREADY = 1'b1;
      end
      @(negedge CLK);
      cyc++;
    end
    RREADY = 1'b0;
    chk("rd_done", 64'(done), 1);
  endtask

  task automatic rd_expect(input string tag, input int len, input logic [31:0] base,
                           input logic [1:0] resp);
    chk({tag, "_n"}, 64'(rd_n), 64'(len + 1));
    for (int i = 0; i <= len && i < 16; i++) begin
      chk($sformatf("%s_dat%0d", tag, i), 64'(rd_dat[i]), 64'(base + 32'(i)));
      chk($sformatf("%s_last%0d", tag, i), 64'(rd_last[i]), 64'(i == len));
      chk($sformatf("%s_resp%0d", tag, i), 64'(rd_resp[i]), 64'(resp));
    end
  endtask

  task automatic w_beats(input int nb, input logic [31:0] d0, input logic [3:0] strb,
                         input int last_at);
    int n = 0;
    int b = 0;
    while (b < nb && n < 50) begin
      WVALID = 1'b1; WDATA = d0 + 32'(b); WSTRB = strb; WLAST = (b == last_at);
      #1;
      if (WREADY) begin w_a[b] = SRAM_A; w_web[b] = SRAM_WEB; b++; end
      @(negedge CLK);
      n++;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    chk("w_done", 64'(b), 64'(nb));
  endtask

  task automatic b_wait;
    int n = 0;
    BREADY = 1'b1;
    while (!BVALID && n < 20) begin @(negedge CLK); n++; end
    chk("b_vld", 64'(BVALID), 1);
    b_resp = BRESP; b_id = BID;
    @(negedge CLK);
    BREADY = 1'b0;
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_arrdy"}, 64'(ARREADY), 0);
    chk({tag, "_awrdy"}, 64'(AWREADY), 0);
    chk({tag, "_wrdy"},  64'(WREADY), 0);
    chk({tag, "_rvld"},  64'(RVALID), 0);
    chk({tag, "_rlast"}, 64'(RLAST), 0);
    chk({tag, "_rdata"}, 64'(RDATA), 0);
    chk({tag, "_rid"},   64'(RID), 0);
    chk({tag, "_rresp"}, 64'(RRESP), 0);
    chk({tag, "_bvld"},  64'(BVALID), 0);
    chk({tag, "_bid"},   64'(BID), 0);
    chk({tag, "_bresp"}, 64'(BRESP), 0);
    chk({tag, "_web"},   64'(SRAM_WEB), 64'hF);
    chk({tag, "_sa"},    64'(SRAM_A), 0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    reset_outputs("rst");
    RSTn = 1'b1;
    @(negedge CLK);

    // Basic INCR read of words 0x40..0x43
    ar_hs(8'h5A, 32'h100, 8'd3, 3'd2, 2'b01);
    rd_lat();
    rd_collect(-1, 0, 32'h0, 16);
    rd_expect("rd", 3, 32'hA000_0040, 2'b00);
    chk("rd_id", 64'(rd_id), 64'h5A);

    // Same read with RREADY held low for 3 cycles at beat 1
    ar_hs(8'h5B, 32'h100, 8'd3, 3'd2, 2'b01);
    rd_lat();
    rd_collect(1, 3, 32'hA000_0041, 16);
    rd_expect("rds", 3, 32'hA000_0040, 2'b00);

    // Two AR/AW collisions: read first, then write
    ARID = 8'h21; ARADDR = 32'h10C; ARLEN = 8'd0; ARSIZE = 3'd2; ARBURST = 2'b01;
    AWID = 8'h22; AWADDR = 32'h300; AWLEN = 8'd0; AWSIZE = 3'd2; AWBURST = 2'b01;
    ARVALID = 1'b1; AWVALID = 1'b1;
    #1;
    chk("col1_ar", 64'(ARREADY), 1);
    chk("col1_aw", 64'(AWREADY), 0);
    @(negedge CLK);
    ARVALID = 1'b0; AWVALID = 1'b0;
    rd_lat();
    rd_collect(-1, 0, 32'h0, 16);
    rd_expect("col_rd", 0, 32'hA000_0043, 2'b00);
    ARVALID = 1'b1; AWVALID = 1'b1;
    #1;
    chk("col2_aw", 64'(AWREADY), 1);
    chk("col2_ar", 64'(ARREADY), 0);
    @(negedge CLK);
    ARVALID = 1'b0; AWVALID = 1'b0;
    w_beats(1, 32'hCAFE_0000, 4'hF, 0);
    chk("col_wa", 64'(w_a[0]), 64'h0C0);
    chk("col_web", 64'(w_web[0]), 0);
    b_wait();
    chk("col_bresp", 64'(b_resp), 0);
    chk("col_bid", 64'(b_id), 64'h22);

    // INCR write, then a partial-strobe write, then read back
    aw_hs(8'h33, 32'h200, 8'd1, 3'd2, 2'b01);
    w_beats(2, 32'h1122_3344, 4'hF, 1);
    chk("wr_a0", 64'(w_a[0]), 64'h080);
    chk("wr_a1", 64'(w_a[1]), 64'h081);
    chk("wr_web1", 64'(w_web[1]), 0);
    b_wait();
    chk("wr_bresp", 64'(b_resp), 0);
    chk("wr_bid", 64'(b_id), 64'h33);
    aw_hs(8'h34, 32'h208, 8'd0, 3'd2, 2'b01);
    w_beats(1, 32'h5566_7788, 4'h3, 0);
    chk("ws_web", 64'(w_web[0]), 64'hC);
    b_wait();
    ar_hs(8'h35, 32'h200, 8'd2, 3'd2, 2'b01);
    rd_lat();
    rd_collect(-1, 0, 32'h0, 16);
    chk("rb_n", 64'(rd_n), 3);
    chk("rb_d0", 64'(rd_dat[0]), 64'h1122_3344);
    chk("rb_d1", 64'(rd_dat[1]), 64'h1122_3345);
    chk("rb_d2", 64'(rd_dat[2]), 64'hA000_7788);

    // WLAST asserted early: SLVERR but data still written
    aw_hs(8'h40, 32'h400, 8'd1, 3'd2, 2'b01);
    w_beats(2, 32'h0BAD_0000, 4'hF, 0);
    chk("wl_web0", 64'(w_web[0]), 0);
    b_wait();
    chk("wl_bresp", 64'(b_resp), 64'h2);

    // WRAP write at 0x38, 4 beats of 4 bytes
    aw_hs(8'h41, 32'h38, 8'd3, 3'd2, 2'b10);
    w_beats(4, 32'hDEAD_0000, 4'hF, 3);
    b_wait();
`ifdef AXI_SRAM_WRAP_EN
    chk("wrap_a0", 64'(w_a[0]), 64'h0E);
    chk("wrap_a1", 64'(w_a[1]), 64'h0F);
    chk("wrap_a2", 64'(w_a[2]), 64'h0C);
    chk("wrap_a3", 64'(w_a[3]), 64'h0D);
    chk("wrap_web", 64'(w_web[2]), 0);
    chk("wrap_bresp", 64'(b_resp), 0);
`else
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_web%0d", i), 64'(w_web[i]), 64'hF);
    chk("wrap_bresp", 64'(b_resp), 64'h2);
`endif

    // Out-of-range write: suppressed, DECERR
    aw_hs(8'h42, 32'h0001_0000, 8'd0, 3'd2, 2'b01);
    w_beats(1, 32'h1234_5678, 4'hF, 0);
    chk("dec_web", 64'(w_web[0]), 64'hF);
    b_wait();
    chk("dec_bresp", 64'(b_resp), 64'h3);

    // Oversized read: SLVERR, data zeroed
    ar_hs(8'h43, 32'h100, 8'd0, 3'd3, 2'b01);
    rd_lat();
    rd_collect(-1, 0, 32'h0, 16);
    chk("sz_resp", 64'(rd_resp[0]), 64'h2);
    chk("sz_dat", 64'(rd_dat[0]), 0);
    chk("sz_last", 64'(rd_last[0]), 1);

    // Reset in the middle of a read burst, then a clean read
    ar_hs(8'h77, 32'h100, 8'd7, 3'd2, 2'b01);
    rd_lat();
    rd_collect(-1, 0, 32'h0, 2);
    RSTn = 1'b0;
    #1;
    reset_outputs("mid");
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    ar_hs(8'h12, 32'h104, 8'd0, 3'd2, 2'b01);
    rd_lat();
    rd_collect(-1, 0, 32'h0, 16);
    rd_expect("post", 0, 32'hA000_0041, 2'b00);
    chk("post_id", 64'(rd_id), 64'h12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
